// File: rtl/res_stream_out_pkg.sv
// Shared types and constants for the RES RAM output stage (state encoding, skid depth,
// defaults shared with the inference block).
package res_stream_out_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int RES_RD_LATENCY     = 1;
  localparam int SKID_DEPTH         = 2;
  localparam int RES_WIDTH_DEF      = 8;
  localparam int RES_DEPTH_BITS_DEF = 6;
  localparam int SKID_CW            = $clog2(SKID_DEPTH + 1);

  // A new read may go out only if the entry it lands in is guaranteed free at capture,
  // counting the slot released by a pop in the same cycle.
  function automatic logic can_issue(input logic [SKID_CW-1:0] occ,
                                     input logic in_flight,
                                     input logic pop);
    return (int'(occ) + int'(in_flight) - int'(pop)) < SKID_DEPTH;
  endfunction

endpackage

// File: rtl/res_skid_fifo.sv
// Small synchronous FIFO (SKID_DEPTH entries) holding captured RES words until the
// stream sink accepts them. Head entry is presented combinationally from storage.
module res_skid_fifo
  import res_stream_out_pkg::*;
#(
  parameter int W = RES_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head_data,
  output logic               full,
  output logic               empty,
  output logic [SKID_CW-1:0] count
);

  logic [SKID_DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [SKID_CW-1:0]           count_q, count_d;
  logic                         do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == SKID_CW'(SKID_DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/res_stream_out.sv
// Drains the RES RAM after Start and streams NUM_RESULTS words as an AXI4-Stream master.
// Optional RES_CLASSIFY_EN: each beat becomes a 1-bit class label (data >= THRESHOLD).
module res_stream_out
  import res_stream_out_pkg::*;
#(
  parameter int               width          = RES_WIDTH_DEF,
  parameter int               RES_depth_bits = RES_DEPTH_BITS_DEF,
  parameter int               NUM_RESULTS    = 64,
  parameter logic [width-1:0] THRESHOLD      = 8'd128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  output logic                      Done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic [width-1:0]          M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST
);

  // One spare bit so the read counter can rest at NUM_RESULTS without wrapping.
  localparam int             CW     = RES_depth_bits + 1;
  localparam logic [CW-1:0]  N_RES  = CW'(NUM_RESULTS);
  localparam logic [CW-1:0]  N_LAST = CW'(NUM_RESULTS - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic               in_flight_q, in_flight_d;

  logic [width-1:0]   head_data;
  logic [width-1:0]   push_data;
  logic               fifo_full, fifo_empty;
  logic [SKID_CW-1:0] fifo_occ;
  logic               hs, issue;

  assign hs    = !fifo_empty && M_AXIS_TREADY;
  assign issue = (state_q == STREAM) && (rd_cnt_q < N_RES) && !fifo_full &&
                 can_issue(fifo_occ, in_flight_q, hs);

`ifdef RES_CLASSIFY_EN
  always_comb begin
    push_data    = '0;
    push_data[0] = (RES_read_data_out >= THRESHOLD);
  end
`else
  assign push_data = RES_read_data_out;
`endif

  res_skid_fifo #(.W(width)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (push_data),
    .pop       (hs),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_occ)
  );

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    in_flight_d = issue;
    case (state_q)
      IDLE: begin
        if (Start) begin
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (hs) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
          if (tx_cnt_q == N_LAST) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      in_flight_q <= in_flight_d;
    end
  end

  // The buffer is empty by the time FINISH is reached, so Done never overlaps TVALID.
  assign Done             = (state_q == FINISH);
  assign RES_read_en      = issue;
  assign RES_read_address = rd_cnt_q[RES_depth_bits-1:0];
  assign M_AXIS_TVALID    = !fifo_empty;
  assign M_AXIS_TDATA     = head_data;
  assign M_AXIS_TLAST     = !fifo_empty && (tx_cnt_q == N_LAST);

endmodule

// File: tb/tb_res_stream_out.sv
// Directed bench for res_stream_out: full runs under several TREADY patterns, stall,
// mid-run reset and repeated Start; classification vectors when RES_CLASSIFY_EN is set.
module tb_res_stream_out;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic       Done;
  logic       RES_read_en;
  logic [5:0] RES_read_address;
  logic [7:0] RES_read_data_out;
  logic [7:0] M_AXIS_TDATA;
  logic       M_AXIS_TVALID;
  logic       M_AXIS_TREADY;
  logic       M_AXIS_TLAST;

  always #5 clk = ~clk;

  res_stream_out dut (
    .clk               (clk),
    .rst               (rst),
    .Start             (Start),
    .Done              (Done),
    .RES_read_en       (RES_read_en),
    .RES_read_address  (RES_read_address),
    .RES_read_data_out (RES_read_data_out),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TREADY     (M_AXIS_TREADY),
    .M_AXIS_TLAST      (M_AXIS_TLAST)
  );

  // RES RAM model, one-cycle read latency
  logic [7:0] ram [N];
  always @(posedge clk) if (RES_read_en) RES_read_data_out <= ram[RES_read_address];

  function automatic logic [7:0] init_val(input int i);
`ifdef RES_CLASSIFY_EN
    case (i)
      0: return 8'd127;
      1: return 8'd128;
      2: return 8'd255;
      3: return 8'd0;
      default: return 8'(3 * i);
    endcase
`else
    return 8'(3 * i);
`endif
  endfunction

  function automatic logic [7:0] exp_val(input int i);
`ifdef RES_CLASSIFY_EN
    return {7'd0, init_val(i) >= 8'd128};
`else
    return 8'(3 * i);
`endif
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: everything sampled on the falling edge, away from the active edge
  int   cyc = 0;
  int   start_cyc, first_vld, first_hs, last_hs, done_cyc;
  int   n_done, n_rd, max_out, stab_err, done_vld_err;
  int   rd_addrs[$];
  int   beats[$];
  int   lasts[$];
  logic prev_v, prev_r, prev_l;
  logic [7:0] prev_d;

  task automatic clr_mon();
    start_cyc = -1; first_vld = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
    n_done = 0; n_rd = 0; max_out = 0; stab_err = 0; done_vld_err = 0;
    rd_addrs.delete(); beats.delete(); lasts.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (Start && start_cyc < 0) start_cyc = cyc;
      if (M_AXIS_TVALID && first_vld < 0) first_vld = cyc;
      if (n_rd - beats.size() > max_out) max_out = n_rd - beats.size();
      if (prev_v && !prev_r &&
          (!M_AXIS_TVALID || M_AXIS_TDATA != prev_d || M_AXIS_TLAST != prev_l))
        stab_err++;
      if (RES_read_en) begin
        rd_addrs.push_back(int'(RES_read_address));
        n_rd++;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beats.push_back(int'(M_AXIS_TDATA));
        lasts.push_back(int'(M_AXIS_TLAST));
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (Done) begin
        n_done++;
        done_cyc = cyc;
        if (M_AXIS_TVALID) done_vld_err++;
      end
      prev_v = M_AXIS_TVALID; prev_r = M_AXIS_TREADY;
      prev_d = M_AXIS_TDATA;  prev_l = M_AXIS_TLAST;
    end
  end

  // Caller is at #1 after a rising edge. mode 0: ready high; 1: ready 1,0,0,1; 2: stall 20.
  task automatic run(input int mode, input int restart_at, input int abort_at);
    int c = 0;
    clr_mon();
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    while (n_done == 0 && c < 2000 && beats.size() < abort_at) begin
      case (mode)
        1:       M_AXIS_TREADY = (c % 4 == 0) || (c % 4 == 3);
        2:       M_AXIS_TREADY = (c >= 20);
        default: M_AXIS_TREADY = 1'b1;
      endcase
      Start = (c == restart_at);
      if (mode == 2 && c == 20) begin
        chk("stall_nreads", rd_addrs.size(), 2);
        if (rd_addrs.size() >= 2) begin
          chk("stall_addr0", rd_addrs[0], 0);
          chk("stall_addr1", rd_addrs[1], 1);
        end
        chk("stall_rd_en_low", RES_read_en, 0);
      end
      @(posedge clk); #1;
      c++;
    end
    Start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int seq_err = 0;
    int n_last = 0;
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_nbeats"}, beats.size(), N);
    for (int i = 0; i < beats.size() && i < N; i++) begin
      chk($sformatf("%s_data%0d", tag, i), beats[i], exp_val(i));
      n_last += lasts[i];
    end
    chk({tag, "_nlast"}, n_last, 1);
    if (lasts.size() == N) chk({tag, "_last_on_final"}, lasts[N-1], 1);
    chk({tag, "_done_latency"}, done_cyc - last_hs, 1);
    chk({tag, "_done_vs_tvalid"}, done_vld_err, 0);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_occ_le2"}, max_out <= 2, 1);
    chk({tag, "_nreads"}, rd_addrs.size(), N);
    foreach (rd_addrs[i]) if (rd_addrs[i] != i) seq_err++;
    chk({tag, "_addr_seq"}, seq_err, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) ram[i] = init_val(i);
    rst = 1'b1; Start = 1'b0; M_AXIS_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", Done, 0);
    chk("rst_rd_en", RES_read_en, 0);
    chk("rst_addr", RES_read_address, 0);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_rd_en", RES_read_en, 0);
    chk("idle_tvalid", M_AXIS_TVALID, 0);

    // Streaming at full rate; Start sampled at edge 0, TVALID rises at edge 2
    run(0, -1, N + 1);
    chk("first_tvalid_latency", first_vld - start_cyc, 3);
    chk("no_bubbles", last_hs - first_hs, N - 1);
    check_run("full");
`ifdef RES_CLASSIFY_EN
    if (beats.size() >= 4) begin
      chk("cls_127", beats[0], 0);
      chk("cls_128", beats[1], 1);
      chk("cls_255", beats[2], 1);
      chk("cls_0",   beats[3], 0);
    end
`endif

    run(1, -1, N + 1);
    check_run("toggle");

    run(2, -1, N + 1);
    if (rd_addrs.size() > 2) chk("resume_addr", rd_addrs[2], 2);
    check_run("stall");

    // Reset after 10 beats; outputs drop immediately, then a clean restart
    run(0, -1, 10);
    chk("pre_rst_beats", beats.size(), 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", M_AXIS_TVALID, 0);
    chk("mid_rst_tdata", M_AXIS_TDATA, 0);
    chk("mid_rst_tlast", M_AXIS_TLAST, 0);
    chk("mid_rst_rd_en", RES_read_en, 0);
    chk("mid_rst_addr", RES_read_address, 0);
    chk("mid_rst_done", Done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, -1, N + 1);
    check_run("restart");

    // Second Start in mid-stream is ignored
    run(0, 30, N + 1);
    check_run("restart_ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
